// File: rtl/spi_sram_responder.sv
// spi_sram_responder: Wishbone B4 classic slave that turns single-beat byte
// reads/writes into READ (0x03) / WRITE (0x02) frames on a serial SPI SRAM.
// Every pin is driven from a register; the pin registers are loaded from the
// state held during the previous cycle, so pins trail the state by one cycle.
module spi_sram_responder #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  input  logic [1:0]            sram_config_i,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic [2:0]            spi_cs_n_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [6:0] LAST_CNT = 7'd79;

  state_t      state_r;
  logic [39:0] frame_r;
  logic [2:0]  cs_sel_r;
  logic        we_r;
  logic [6:0]  cnt_r;
  logic [6:0]  rx_r;

  logic [23:0] spi_adr_s;
  logic [39:0] frame_s;

  // Active-low chip-select pattern for a configuration value; 3 selects nothing.
  function automatic logic [2:0] decode_cs(input logic [1:0] cfg);
    logic [2:0] cs;
    case (cfg)
      2'd0:    cs = 3'b110;
      2'd1:    cs = 3'b101;
      2'd2:    cs = 3'b011;
      default: cs = 3'b111;
    endcase
    return cs;
  endfunction

  assign wbs_rty_o = 1'b0;

  // Build the outgoing frame: command, 24-bit address, data byte (0 for reads).
  always_comb begin
    spi_adr_s = 24'(wbs_adr_i);
    if (wbs_we_i) begin
      frame_s = {8'h02, spi_adr_s, wbs_dat_i};
    end else begin
      frame_s = {8'h03, spi_adr_s, 8'h00};
    end
  end

  // Transaction FSM together with every registered Wishbone and SPI output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      frame_r    <= 40'h0;
      cs_sel_r   <= 3'b111;
      we_r       <= 1'b0;
      cnt_r      <= 7'd0;
      rx_r       <= 7'd0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_dat_o  <= 8'h00;
      spi_sck_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_n_o <= 3'b111;
    end else begin
      case (state_r)
        IDLE: begin
          wbs_ack_o  <= 1'b0;
          wbs_err_o  <= 1'b0;
          spi_sck_o  <= 1'b0;
          spi_mosi_o <= 1'b0;
          spi_cs_n_o <= 3'b111;
          if (wbs_cyc_i && wbs_stb_i) begin
            frame_r  <= frame_s;
            we_r     <= wbs_we_i;
            cs_sel_r <= decode_cs(sram_config_i);
            cnt_r    <= 7'd0;
            rx_r     <= 7'd0;
            state_r  <= (sram_config_i == 2'd3) ? ERR : SHIFT;
          end
        end
        SHIFT: begin
          wbs_ack_o <= 1'b0;
          wbs_err_o <= 1'b0;
          if (!wbs_cyc_i) begin
            // Master abandoned the cycle: release the bus without an ack.
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            spi_cs_n_o <= 3'b111;
            cnt_r      <= 7'd0;
            state_r    <= IDLE;
          end else begin
            spi_cs_n_o <= cs_sel_r;
            if (!cnt_r[0]) begin
              // Phase 0: clock low, present next bit; the previous phase 1 just ended.
              spi_sck_o  <= 1'b0;
              spi_mosi_o <= frame_r[39];
              frame_r    <= {frame_r[38:0], 1'b0};
              if (cnt_r != 7'd0) begin
                rx_r <= {rx_r[5:0], spi_miso_i};
              end
            end else begin
              spi_sck_o <= 1'b1;
            end
            if (cnt_r == LAST_CNT) begin
              state_r <= ACK;
            end else begin
              cnt_r <= cnt_r + 7'd1;
            end
          end
        end
        ACK: begin
          // The last phase 1 ends here, so the final MISO bit joins the byte directly.
          wbs_ack_o  <= 1'b1;
          wbs_err_o  <= 1'b0;
          spi_sck_o  <= 1'b0;
          spi_mosi_o <= 1'b0;
          spi_cs_n_o <= 3'b111;
          if (!we_r) begin
            wbs_dat_o <= {rx_r, spi_miso_i};
          end
          cnt_r   <= 7'd0;
          state_r <= IDLE;
        end
        ERR: begin
          wbs_ack_o  <= 1'b0;
          wbs_err_o  <= 1'b1;
          spi_sck_o  <= 1'b0;
          spi_mosi_o <= 1'b0;
          spi_cs_n_o <= 3'b111;
          state_r    <= IDLE;
        end
        default: begin
          wbs_ack_o  <= 1'b0;
          wbs_err_o  <= 1'b0;
          spi_sck_o  <= 1'b0;
          spi_mosi_o <= 1'b0;
          spi_cs_n_o <= 3'b111;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: a byte-wide SPI SRAM device model on the pins,
// a reference memory kept at transaction level, and scoreboard queues that a
// response monitor and a frame monitor drain independently of the stimulus.
module tb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [23:0] wbs_adr_i = 24'h0;
  logic        wbs_we_i = 1'b0;
  logic [7:0]  wbs_dat_i = 8'h0;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;
  logic [7:0]  wbs_dat_o;
  logic [1:0]  sram_config_i = 2'd0;
  logic        spi_sck_o;
  logic        spi_mosi_o;
  logic        spi_miso_i = 1'b0;
  logic [2:0]  spi_cs_n_o;

  spi_sram_responder #(.ADDR_WIDTH(24)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
    .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbs_dat_o(wbs_dat_o), .sram_config_i(sram_config_i),
    .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
    .spi_cs_n_o(spi_cs_n_o)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  // Count active clock edges so response times can be stated in edges.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Power-on contents of the SRAM: a simple hash of the address.
  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5B;
  endfunction

  // ---------------- expected responses and frames ----------------
  typedef struct {
    bit         is_err;
    logic [7:0] rdata;
    int         resp_cycle;
  } exp_t;
  typedef struct {
    logic [39:0] frame;
    logic [2:0]  cs;
  } spi_exp_t;

  exp_t        sb_q[$];
  spi_exp_t    spi_q[$];
  logic [7:0]  ref_mem[int];
  logic [7:0]  last_rd = 8'h00;

  function automatic logic [7:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [2:0] cs_of(input logic [1:0] cfg);
    logic [2:0] v;
    v = 3'b111;
    v[cfg] = 1'b0;
    return v;
  endfunction

  // Model one accepted request: queue its response and, if it reaches the SRAM, its frame.
  task automatic model_req(input bit we, input logic [23:0] a, input logic [7:0] d,
                           input logic [1:0] cfg, input int t0);
    exp_t e;
    spi_exp_t s;
    if (cfg == 2'd3) begin
      e.is_err = 1'b1; e.rdata = last_rd; e.resp_cycle = t0 + 1;
    end else begin
      if (we) ref_mem[int'(a)] = d;
      else last_rd = ref_read(a);
      e.is_err = 1'b0; e.rdata = last_rd; e.resp_cycle = t0 + 81;
      s.frame = {(we ? 8'h02 : 8'h03), a, (we ? d : 8'h00)};
      s.cs = cs_of(cfg);
      spi_q.push_back(s);
    end
    sb_q.push_back(e);
  endtask

  // ---------------- response monitor ----------------
  // Pop the oldest expected response whenever ack or err is presented.
  always @(negedge clk) begin
    if (rst_ni && (wbs_ack_o || wbs_err_o)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {wbs_ack_o, wbs_err_o}, 2'b00);
      end else begin
        check("resp_kind", {wbs_ack_o, wbs_err_o}, sb_q[0].is_err ? 2'b01 : 2'b10);
        check("resp_cycle", cyc_cnt, sb_q[0].resp_cycle);
        check("dat_o", wbs_dat_o, sb_q[0].rdata);
        sb_q.delete(0);
      end
    end
  end

  // ---------------- SPI SRAM device model and frame monitor ----------------
  logic [7:0]  dev_mem[256];
  bit          dev_vld[256];
  logic [39:0] cap = 40'h0;
  int          bit_cnt = 0;
  int          low_cycles = 0;
  logic [2:0]  frame_cs = 3'b111;
  bit          bad_cs = 1'b0;
  logic        prev_sck = 1'b0;

  function automatic logic dev_bit(input logic [23:0] a, input int idx);
    logic [7:0] b;
    b = dev_vld[a[7:0]] ? dev_mem[a[7:0]] : dflt(a);
    return b[7 - idx];
  endfunction

  // Capture MOSI on SCK rising, drive read data during the high phase, close frames on CS release.
  always @(negedge clk) begin
    prev_sck <= spi_sck_o;
    if (spi_cs_n_o != 3'b111) begin
      low_cycles <= low_cycles + 1;
      frame_cs <= spi_cs_n_o;
      if (!(spi_cs_n_o inside {3'b110, 3'b101, 3'b011}) ||
          (low_cycles != 0 && spi_cs_n_o != frame_cs)) bad_cs <= 1'b1;
      if (spi_sck_o && !prev_sck && bit_cnt < 40) begin
        cap[39 - bit_cnt] <= spi_mosi_o;
        bit_cnt <= bit_cnt + 1;
        if (bit_cnt >= 32 && cap[39:32] == 8'h03) spi_miso_i <= dev_bit(cap[31:8], bit_cnt - 32);
        else spi_miso_i <= 1'($urandom);
      end
    end else if (low_cycles != 0) begin
      if (bit_cnt == 40) begin
        if (spi_q.size() == 0) begin
          check("frame_expected", spi_q.size(), 1);
        end else begin
          check("frame_bits", cap, spi_q[0].frame);
          check("frame_cs", frame_cs, spi_q[0].cs);
          check("cs_low_cycles", low_cycles, 80);
          check("cs_stable_onehot", bad_cs, 0);
          if (cap[39:32] == 8'h02) begin
            dev_mem[cap[15:8]] <= cap[7:0];
            dev_vld[cap[15:8]] <= 1'b1;
          end
          spi_q.delete(0);
        end
      end
      low_cycles <= 0;
      bit_cnt <= 0;
      bad_cs <= 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input bit we, input logic [23:0] a, input logic [7:0] d, input logic [1:0] cfg);
    int t0;
    bit done;
    bit idle_bad;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d; sram_config_i = cfg;
    t0 = cyc_cnt + 1;
    model_req(we, a, d, cfg, t0);
    done = 1'b0;
    idle_bad = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        wbs_adr_i = 24'($urandom); wbs_dat_i = 8'($urandom); sram_config_i = 2'($urandom);
      end
      if (spi_cs_n_o != 3'b111 || spi_sck_o) idle_bad = 1'b1;
      if (wbs_ack_o || wbs_err_o) done = 1'b1;
    end
    check("resp_seen", done, 1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (cfg == 2'd3) check("err_pins_idle", idle_bad, 0);
  endtask

  task automatic do_abort(input logic [23:0] a);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a; sram_config_i = 2'd1;
    repeat (30) @(negedge clk);
    check("abort_cs_active", spi_cs_n_o, 3'b101);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    check("abort_cs_release", spi_cs_n_o, 3'b111);
    check("abort_sck_low", spi_sck_o, 1'b0);
    repeat (100) @(negedge clk);
    check("abort_dat_o", wbs_dat_o, last_rd);
  endtask

  task automatic do_reset_mid(input logic [23:0] a);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a; sram_config_i = 2'd0;
    repeat (50) @(negedge clk);
    check("rst_pre_cs", spi_cs_n_o, 3'b110);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_cs", spi_cs_n_o, 3'b111);
    check("rst_mid_sck", spi_sck_o, 1'b0);
    check("rst_mid_mosi", spi_mosi_o, 1'b0);
    check("rst_mid_ack", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 3'b000);
    check("rst_mid_dat", wbs_dat_o, 8'h00);
    last_rd = 8'h00;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic do_b2b(input logic [23:0] a, input logic [1:0] cfg);
    int t0;
    int acks;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a; sram_config_i = cfg;
    t0 = cyc_cnt + 1;
    model_req(1'b0, a, 8'h00, cfg, t0);
    model_req(1'b0, a, 8'h00, cfg, t0 + 82);
    acks = 0;
    for (int n = 0; n < 400 && acks < 2; n++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    check("b2b_ack_count", acks, 2);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  function automatic logic [23:0] pool_adr();
    return 24'h000400 + 24'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [1:0] cfg;
    repeat (3) @(negedge clk);
    check("reset_cs", spi_cs_n_o, 3'b111);
    check("reset_pins", {spi_sck_o, spi_mosi_o}, 2'b00);
    check("reset_resp", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 3'b000);
    check("reset_dat", wbs_dat_o, 8'h00);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    do_txn(1'b1, 24'h000400, 8'hA5, 2'd0);
    do_txn(1'b0, 24'h012345, 8'h00, 2'd2);
    check("read_012345", wbs_dat_o, 8'h3C);
    do_txn(1'b0, pool_adr(), 8'h00, 2'd3);
    do_txn(1'b0, 24'h000400, 8'h00, 2'd1);
    do_abort(24'h000401);
    do_txn(1'b0, 24'h000400, 8'h00, 2'd0);
    do_reset_mid(24'h000402);
    do_txn(1'b0, 24'h012345, 8'h00, 2'd1);
    do_b2b(24'h000400, 2'd2);

    for (int i = 0; i < 24; i++) begin
      cfg = ($urandom_range(0, 6) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom), pool_adr(), 8'($urandom), cfg);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("frames_drained", spi_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
